// File: rtl/alu_op_decoder.sv
// Registered RV32I integer-ALU decode stage (OP, OP-IMM, LUI, AUIPC) with a valid/ready output register.
// Define ALU_DECODE_SKID_EN to add a skid entry and a registered in_ready.

`ifndef OPERANDS_WIDTH
`define OPERANDS_WIDTH 32
`endif
`ifndef ALU_SEL_WIDTH
`define ALU_SEL_WIDTH 4
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD  4'd0
`define ALU_OP_SUB  4'd1
`define ALU_OP_SLL  4'd2
`define ALU_OP_SLT  4'd3
`define ALU_OP_SLTU 4'd4
`define ALU_OP_XOR  4'd5
`define ALU_OP_SRL  4'd6
`define ALU_OP_SRA  4'd7
`define ALU_OP_OR   4'd8
`define ALU_OP_AND  4'd9
`define ALU_OP_LUI  4'd10
`endif

module alu_op_decoder (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  inst,
    input  logic [`OPERANDS_WIDTH-1:0]   pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [`ALU_SEL_WIDTH-1:0]    ALUSel,
    output logic                         a_sel,
    output logic                         b_sel,
    output logic [`OPERANDS_WIDTH-1:0]   imm,
    output logic [4:0]                   rs1,
    output logic [4:0]                   rs2,
    output logic [4:0]                   rd,
    output logic                         reg_wen,
    output logic [`OPERANDS_WIDTH-1:0]   out_pc,
    output logic                         illegal
);

    localparam int OPW = `OPERANDS_WIDTH;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef struct packed {
        logic [`ALU_SEL_WIDTH-1:0] alu_sel;
        logic                      a_sel;
        logic                      b_sel;
        logic [OPW-1:0]            imm;
        logic [4:0]                rs1;
        logic [4:0]                rs2;
        logic [4:0]                rd;
        logic                      reg_wen;
        logic                      illegal;
        logic [OPW-1:0]            pc;
    } dec_t;

    // alt selects the funct7[5] variant; only meaningful for funct3 000 and 101.
    function automatic logic [`ALU_SEL_WIDTH-1:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? `ALU_OP_SUB : `ALU_OP_ADD;
            3'b001:  return `ALU_OP_SLL;
            3'b010:  return `ALU_OP_SLT;
            3'b011:  return `ALU_OP_SLTU;
            3'b100:  return `ALU_OP_XOR;
            3'b101:  return alt ? `ALU_OP_SRA : `ALU_OP_SRL;
            3'b110:  return `ALU_OP_OR;
            default: return `ALU_OP_AND;
        endcase
    endfunction

    function automatic logic [OPW-1:0] imm_i(input logic [31:0] ins);
        logic signed [11:0] v;
        v = signed'(ins[31:20]);
        return OPW'(v);
    endfunction

    function automatic logic [OPW-1:0] imm_u(input logic [31:0] ins);
        logic signed [31:0] v;
        v = signed'({ins[31:12], 12'b0});
        return OPW'(v);
    endfunction

    function automatic logic [OPW-1:0] imm_shamt(input logic [31:0] ins);
        return OPW'(ins[24:20]);
    endfunction

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic [4:0] w_rd;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_legal;
    dec_t       w_dec;
    logic       w_xfer_in;

    assign w_opc = inst[6:0];
    assign w_rd  = inst[11:7];
    assign w_f3  = inst[14:12];
    assign w_rs1 = inst[19:15];
    assign w_rs2 = inst[24:20];
    assign w_f7  = inst[31:25];

    always_comb begin
        w_dec         = '0;
        w_dec.alu_sel = `ALU_OP_ADD;
        w_dec.pc      = pc;
        w_legal       = 1'b0;
        case (w_opc)
            OPC_OP: begin
                w_legal = (w_f7 == F7_BASE) ||
                          ((w_f7 == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
                w_dec.alu_sel = alu_of(w_f3, w_f7 == F7_ALT);
                w_dec.rs1     = w_rs1;
                w_dec.rs2     = w_rs2;
                w_dec.rd      = w_rd;
            end
            OPC_OPIMM: begin
                w_dec.b_sel = 1'b1;
                w_dec.rs1   = w_rs1;
                w_dec.rd    = w_rd;
                if (w_f3 == 3'b001) begin
                    w_legal       = (w_f7 == F7_BASE);
                    w_dec.alu_sel = `ALU_OP_SLL;
                    w_dec.imm     = imm_shamt(inst);
                end else if (w_f3 == 3'b101) begin
                    w_legal       = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
                    w_dec.alu_sel = alu_of(w_f3, w_f7 == F7_ALT);
                    w_dec.imm     = imm_shamt(inst);
                end else begin
                    w_legal       = 1'b1;
                    w_dec.alu_sel = alu_of(w_f3, 1'b0);
                    w_dec.imm     = imm_i(inst);
                end
            end
            OPC_LUI: begin
                w_legal       = 1'b1;
                w_dec.alu_sel = `ALU_OP_LUI;
                w_dec.b_sel   = 1'b1;
                w_dec.imm     = imm_u(inst);
                w_dec.rd      = w_rd;
            end
            OPC_AUIPC: begin
                w_legal       = 1'b1;
                w_dec.alu_sel = `ALU_OP_ADD;
                w_dec.a_sel   = 1'b1;
                w_dec.b_sel   = 1'b1;
                w_dec.imm     = imm_u(inst);
                w_dec.rd      = w_rd;
            end
            default: w_legal = 1'b0;
        endcase
        // Illegal entries still travel down the pipe, stripped to a trap marker.
        if (!w_legal) begin
            w_dec         = '0;
            w_dec.alu_sel = `ALU_OP_ADD;
            w_dec.illegal = 1'b1;
            w_dec.pc      = pc;
        end else begin
            w_dec.reg_wen = (w_dec.rd != 5'd0);
        end
    end

    dec_t r_out_p1;
    logic r_vld_p1;

    assign w_xfer_in = in_valid && in_ready;

`ifdef ALU_DECODE_SKID_EN
    // --- stage p1: output register plus one skid entry ---
    dec_t r_skid_p1;
    logic r_skid_vld_p1;
    logic r_in_ready;
    logic w_out_free;
    logic w_skid_vld_nxt;

    assign in_ready       = r_in_ready;
    assign w_out_free     = !r_vld_p1 || out_ready;
    assign w_skid_vld_nxt = !flush && !w_out_free && (r_skid_vld_p1 || w_xfer_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1      <= 1'b0;
            r_skid_vld_p1 <= 1'b0;
            r_in_ready    <= 1'b1;
            r_out_p1      <= '0;
        end else begin
            r_skid_vld_p1 <= w_skid_vld_nxt;
            r_in_ready    <= !w_skid_vld_nxt;
            if (flush) begin
                r_vld_p1 <= 1'b0;
            end else if (w_out_free) begin
                if (r_skid_vld_p1) begin
                    r_out_p1 <= r_skid_p1;
                    r_vld_p1 <= 1'b1;
                end else if (w_xfer_in) begin
                    r_out_p1 <= w_dec;
                    r_vld_p1 <= 1'b1;
                end else begin
                    r_vld_p1 <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!w_out_free && w_xfer_in) begin
            r_skid_p1 <= w_dec;
        end
    end
`else
    // --- stage p1: single output register ---
    assign in_ready = !r_vld_p1 || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_out_p1 <= '0;
        end else if (flush) begin
            r_vld_p1 <= 1'b0;
        end else if (w_xfer_in) begin
            r_out_p1 <= w_dec;
            r_vld_p1 <= 1'b1;
        end else if (out_ready) begin
            r_vld_p1 <= 1'b0;
        end
    end
`endif

    assign out_valid = r_vld_p1;
    assign ALUSel    = r_out_p1.alu_sel;
    assign a_sel     = r_out_p1.a_sel;
    assign b_sel     = r_out_p1.b_sel;
    assign imm       = r_out_p1.imm;
    assign rs1       = r_out_p1.rs1;
    assign rs2       = r_out_p1.rs2;
    assign rd        = r_out_p1.rd;
    assign reg_wen   = r_out_p1.reg_wen;
    assign illegal   = r_out_p1.illegal;
    assign out_pc    = r_out_p1.pc;

endmodule
